// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequenced accumulator ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_LDA = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_CMA = 4'b1001;
    localparam logic [3:0] ALU_CME = 4'b1010;
    localparam logic [3:0] ALU_CIR = 4'b1011;
    localparam logic [3:0] ALU_CIL = 4'b1100;
    localparam logic [3:0] ALU_INP = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_rotate_step.sv
// One-bit circular rotate of the {E,AC} ring; dir_left selects CIL, otherwise CIR.
module alu_rotate_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] ring_in,
    input  logic           dir_left,
    output logic [WIDTH:0] ring_out
);

    // Bit WIDTH of the ring is E; bits WIDTH-1..0 are AC.
    always_comb begin
        if (dir_left) begin
            ring_out = {ring_in[WIDTH-1:0], ring_in[WIDTH]};
        end else begin
            ring_out = {ring_in[0], ring_in[WIDTH:1]};
        end
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered accumulator ALU with start/done handshake; rotates advance one bit per clock.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int INPR_WIDTH = 8,
    parameter int SHAMT_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            alu_code,
    input  logic [SHAMT_W-1:0]    shamt,
    input  logic [WIDTH-1:0]      ac_outdata,
    input  logic [WIDTH-1:0]      dr_outdata,
    input  logic                  e_outdata,
    input  logic [INPR_WIDTH-1:0] inpr_outdata,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      alu_outdata,
    output logic                  e_indata,
    output logic                  ff_en,
    output logic                  z_flag,
    output logic                  n_flag
);

    localparam logic [WIDTH:0]     ONE_EXT = 1;
    localparam logic [SHAMT_W-1:0] ONE_CNT = 1;

    alu_state_e           state_q, state_d;
    logic [SHAMT_W-1:0]   count_q, count_d;
    logic                 dir_q, dir_d;
    logic [WIDTH:0]       ring_q, ring_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 e_q, e_d;
    logic                 ff_wr_q, ff_wr_d;
    logic                 z_q, z_d;
    logic                 n_q, n_d;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_sum;
    logic [WIDTH:0]       step_out;
    logic [WIDTH-1:0]     sc_result;
    logic                 sc_e;
    logic                 sc_ff;
    logic                 is_rotate;

    logic                 load_out;
    logic [WIDTH-1:0]     out_val;
    logic                 out_e;
    logic                 out_ff;

    assign add_sum = {1'b0, ac_outdata} + {1'b0, dr_outdata};
    assign sub_sum = {1'b0, ac_outdata} + {1'b0, ~dr_outdata} + ONE_EXT;

    alu_rotate_step #(
        .WIDTH(WIDTH)
    ) u_rotate_step (
        .ring_in (ring_q),
        .dir_left(dir_q),
        .ring_out(step_out)
    );

    // Result of every op that completes in the start cycle (including zero-length rotates).
    always_comb begin
        sc_result = ac_outdata;
        sc_e      = e_outdata;
        sc_ff     = 1'b0;
        is_rotate = 1'b0;
        case (alu_code)
            ALU_AND: sc_result = ac_outdata & dr_outdata;
            ALU_ADD: begin
                sc_result = add_sum[WIDTH-1:0];
                sc_e      = add_sum[WIDTH];
                sc_ff     = 1'b1;
            end
            ALU_LDA: sc_result = dr_outdata;
            ALU_SUB: begin
                sc_result = sub_sum[WIDTH-1:0];
                sc_e      = sub_sum[WIDTH];
                sc_ff     = 1'b1;
            end
            ALU_CMA: sc_result = ~ac_outdata;
            ALU_CME: begin
                sc_e  = ~e_outdata;
                sc_ff = 1'b1;
            end
            ALU_INP: sc_result = {ac_outdata[WIDTH-1:INPR_WIDTH], inpr_outdata};
            ALU_CIR, ALU_CIL: begin
                sc_ff     = 1'b1;
                is_rotate = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        dir_d    = dir_q;
        ring_d   = ring_q;
        load_out = 1'b0;
        out_val  = result_q;
        out_e    = e_q;
        out_ff   = ff_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_rotate && (shamt != '0)) begin
                        ring_d  = {e_outdata, ac_outdata};
                        count_d = shamt;
                        dir_d   = (alu_code == ALU_CIL);
                        state_d = ST_RUN;
                    end else begin
                        load_out = 1'b1;
                        out_val  = sc_result;
                        out_e    = sc_e;
                        out_ff   = sc_ff;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                ring_d  = step_out;
                count_d = count_q - ONE_CNT;
                // The last step is published straight from the rotator, saving a cycle.
                if (count_q == ONE_CNT) begin
                    load_out = 1'b1;
                    out_val  = step_out[WIDTH-1:0];
                    out_e    = step_out[WIDTH];
                    out_ff   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        result_d = result_q;
        e_d      = e_q;
        ff_wr_d  = ff_wr_q;
        z_d      = z_q;
        n_d      = n_q;
        if (load_out) begin
            result_d = out_val;
            e_d      = out_e;
            ff_wr_d  = out_ff;
            z_d      = (out_val == '0);
            n_d      = out_val[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            dir_q    <= 1'b0;
            ring_q   <= '0;
            result_q <= '0;
            e_q      <= 1'b0;
            ff_wr_q  <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            ring_q   <= ring_d;
            result_q <= result_d;
            e_q      <= e_d;
            ff_wr_q  <= ff_wr_d;
            z_q      <= z_d;
            n_q      <= n_d;
        end
    end

    // ff_en is a pulse even though the E-write decision is held with the result.
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign ff_en       = done & ff_wr_q;
    assign alu_outdata = result_q;
    assign e_indata    = e_q;
    assign z_flag      = z_q;
    assign n_flag      = n_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomized scoreboard bench for alu_seq_unit against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq_unit;

    localparam int W  = 16;
    localparam int IW = 8;
    localparam int SW = 4;

    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_CIR = 4'b1011;
    localparam logic [3:0] OP_CIL = 4'b1100;
    localparam logic [3:0] OP_INP = 4'b1101;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    alu_code;
    logic [SW-1:0] shamt;
    logic [W-1:0]  ac_outdata;
    logic [W-1:0]  dr_outdata;
    logic          e_outdata;
    logic [IW-1:0] inpr_outdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  alu_outdata;
    logic          e_indata;
    logic          ff_en;
    logic          z_flag;
    logic          n_flag;

    typedef struct {
        logic [15:0] res;
        logic        e;
        logic        ff;
        logic        z;
        logic        n;
        int          cyc;
        logic [3:0]  op;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    alu_seq_unit #(
        .WIDTH(W),
        .INPR_WIDTH(IW),
        .SHAMT_W(SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_code    (alu_code),
        .shamt       (shamt),
        .ac_outdata  (ac_outdata),
        .dr_outdata  (dr_outdata),
        .e_outdata   (e_outdata),
        .inpr_outdata(inpr_outdata),
        .busy        (busy),
        .done        (done),
        .alu_outdata (alu_outdata),
        .e_indata    (e_indata),
        .ff_en       (ff_en),
        .z_flag      (z_flag),
        .n_flag      (n_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expected outputs and the negedge index at which done must be seen.
    function automatic exp_t refModel(input logic [3:0] op, input int sh,
                                      input logic [15:0] ac, input logic [15:0] dr,
                                      input logic e, input logic [7:0] inp, input int t);
        exp_t        x;
        logic [31:0] wide;
        logic [16:0] ring;
        x.res = ac;
        x.e   = e;
        x.ff  = 1'b0;
        x.op  = op;
        x.cyc = t;
        case (op)
            4'b0001: x.res = ac & dr;
            4'b0010: begin
                wide  = 32'(ac) + 32'(dr);
                x.res = wide[15:0];
                x.e   = wide[16];
                x.ff  = 1'b1;
            end
            4'b0011: x.res = dr;
            4'b0100: begin
                x.res = ac - dr;
                x.e   = (ac >= dr);
                x.ff  = 1'b1;
            end
            4'b1001: x.res = ~ac;
            4'b1010: begin
                x.e  = ~e;
                x.ff = 1'b1;
            end
            4'b1101: x.res = {ac[15:8], inp};
            4'b1011, 4'b1100: begin
                ring = {e, ac};
                if (sh > 0) begin
                    if (op == OP_CIL) ring = (ring << sh) | (ring >> (17 - sh));
                    else              ring = (ring >> sh) | (ring << (17 - sh));
                end
                x.res = ring[15:0];
                x.e   = ring[16];
                x.ff  = 1'b1;
                x.cyc = t + sh;
            end
            default: ;
        endcase
        x.z = (x.res == 16'h0000);
        x.n = x.res[15];
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected response.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'(0));
            end else begin
                x = sbq.pop_front();
                checkOutput($sformatf("op%0h_latency", x.op), 32'(cyc), 32'(x.cyc));
                checkOutput($sformatf("op%0h_result", x.op), 32'(alu_outdata), 32'(x.res));
                checkOutput($sformatf("op%0h_e", x.op), 32'(e_indata), 32'(x.e));
                checkOutput($sformatf("op%0h_ff_en", x.op), 32'(ff_en), 32'(x.ff));
                checkOutput($sformatf("op%0h_z", x.op), 32'(z_flag), 32'(x.z));
                checkOutput($sformatf("op%0h_n", x.op), 32'(n_flag), 32'(x.n));
            end
        end
    end

    // Called on a negedge with the DUT idle; returns one negedge after the start edge.
    task automatic applyStimulus(input logic [3:0] op, input int sh, input logic [15:0] ac,
                                 input logic [15:0] dr, input logic e, input logic [7:0] inp);
        alu_code     = op;
        shamt        = SW'(sh);
        ac_outdata   = ac;
        dr_outdata   = dr;
        e_outdata    = e;
        inpr_outdata = inp;
        start        = 1'b1;
        sbq.push_back(refModel(op, sh, ac, dr, e, inp, cyc + 1));
        @(negedge clk);
        start        = 1'b0;
        alu_code     = 4'($urandom);
        shamt        = SW'($urandom);
        ac_outdata   = 16'($urandom);
        dr_outdata   = 16'($urandom);
        e_outdata    = 1'($urandom);
        inpr_outdata = 8'($urandom);
    endtask

    task automatic waitDone();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) checkOutput("done_timeout", 32'(done), 32'(1));
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'(0));
        checkOutput({tag, "_done"}, 32'(done), 32'(0));
        checkOutput({tag, "_alu_outdata"}, 32'(alu_outdata), 32'(0));
        checkOutput({tag, "_e_indata"}, 32'(e_indata), 32'(0));
        checkOutput({tag, "_ff_en"}, 32'(ff_en), 32'(0));
        checkOutput({tag, "_z_flag"}, 32'(z_flag), 32'(0));
        checkOutput({tag, "_n_flag"}, 32'(n_flag), 32'(0));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : driver
        reset        = 1'b1;
        start        = 1'b0;
        alu_code     = 4'h0;
        shamt        = '0;
        ac_outdata   = '0;
        dr_outdata   = '0;
        e_outdata    = 1'b0;
        inpr_outdata = '0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(OP_ADD, 0, 16'hFFFF, 16'h0001, 1'b0, 8'h00);
        waitDone();
        applyStimulus(OP_SUB, 0, 16'h0005, 16'h0007, 1'b1, 8'h00);
        waitDone();
        applyStimulus(OP_SUB, 0, 16'h0007, 16'h0005, 1'b0, 8'h00);
        waitDone();
        applyStimulus(OP_CIR, 1, 16'h0001, 16'h0000, 1'b0, 8'h00);
        waitDone();
        applyStimulus(OP_CIR, 0, 16'hA5C3, 16'h0000, 1'b1, 8'h00);
        waitDone();

        // CIL by 3 with an ADD request thrown at it while busy.
        applyStimulus(OP_CIL, 3, 16'h8000, 16'h1234, 1'b1, 8'h00);
        checkOutput("cil_busy_1", 32'(busy), 32'(1));
        alu_code   = OP_ADD;
        ac_outdata = 16'h1111;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("cil_busy_2", 32'(busy), 32'(1));
        @(negedge clk);
        checkOutput("cil_busy_3", 32'(busy), 32'(1));
        waitDone();

        applyStimulus(OP_INP, 0, 16'h12AB, 16'h0000, 1'b1, 8'hCD);
        waitDone();

        // Reset during the second rotate step: outputs clear at once and no done follows.
        applyStimulus(OP_CIR, 5, 16'h3C5A, 16'h0000, 1'b1, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkAllZero("midrun_reset");
        void'(sbq.pop_back());
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        applyStimulus(OP_AND, 0, 16'hF0F0, 16'h3C3C, 1'b0, 8'h00);
        waitDone();

        for (int i = 0; i < 150; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom_range(0, 15), 16'($urandom),
                          16'($urandom), 1'($urandom), 8'($urandom));
            waitDone();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
